neuron_mac_ctrl: RTL and testbench



---
 rtl/neuron_mac_ctrl.sv | 99 +++++++++
 tb/tb_neuron_mac_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/neuron_mac_ctrl.sv
// Neuron dot-product sequencer: streams weight/input pairs through a shared
// external multiplier, accumulates the products, adds bias, then hands off the result.
module neuron_mac_ctrl #(
    parameter int INP_WIDTH  = 16,
    parameter int ACC_WIDTH  = 40,
    parameter int N_INPUTS   = 784,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic signed [INP_WIDTH-1:0]   bias,
    output logic                          busy,
    output logic                          mem_rd_en,
    output logic        [ADDR_WIDTH-1:0]  mem_addr,
    input  logic signed [INP_WIDTH-1:0]   w_data,
    input  logic signed [INP_WIDTH-1:0]   x_data,
    output logic signed [INP_WIDTH-1:0]   mult_a,
    output logic signed [INP_WIDTH-1:0]   mult_b,
    input  logic signed [2*INP_WIDTH-1:0] mult_out,
    output logic signed [ACC_WIDTH-1:0]   result,
    output logic                          result_valid,
    input  logic                          result_ready
);

    typedef enum logic [2:0] {IDLE, RUN, TAIL, BIAS, OUT} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(N_INPUTS - 1);

    state_t                        state;
    logic                          acc_en;
    logic signed [INP_WIDTH-1:0]   bias_q;
    logic signed [ACC_WIDTH-1:0]   acc;
    logic signed [ACC_WIDTH-1:0]   prod_ext;
    logic signed [ACC_WIDTH-1:0]   bias_ext;

    assign mult_a   = w_data;
    assign mult_b   = x_data;
    assign prod_ext = ACC_WIDTH'(mult_out);
    assign bias_ext = ACC_WIDTH'(bias_q);

    // acc_en trails mem_rd_en by the memory latency, so it is high exactly
    // while a fresh product sits on mult_out (RUN cycles 2..N plus TAIL).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            acc_en       <= 1'b0;
            acc          <= '0;
            bias_q       <= '0;
            busy         <= 1'b0;
            mem_rd_en    <= 1'b0;
            mem_addr     <= '0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            acc_en <= mem_rd_en;
            if (acc_en)
                acc <= acc + prod_ext;

            case (state)
                IDLE: begin
                    if (start) begin
                        acc       <= '0;
                        bias_q    <= bias;
                        mem_addr  <= '0;
                        mem_rd_en <= 1'b1;
                        busy      <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (mem_addr == LAST_ADDR) begin
                        mem_rd_en <= 1'b0;
                        state     <= TAIL;
                    end else begin
                        mem_addr <= mem_addr + 1'b1;
                    end
                end
                TAIL: state <= BIAS;
                BIAS: begin
                    acc          <= acc + bias_ext;
                    result       <= acc + bias_ext;
                    result_valid <= 1'b1;
                    state        <= OUT;
                end
                OUT: begin
                    // A start arriving in the accept cycle is deliberately dropped.
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_mac_ctrl.sv
// Directed self-checking bench for neuron_mac_ctrl with N_INPUTS=4; a second
// instance with a 32-bit accumulator exercises wrap-around.
module tb_neuron_mac_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic signed [15:0] bias;
    logic result_ready;

    logic               busy, mem_rd_en, result_valid;
    logic [9:0]         mem_addr;
    logic signed [15:0] w_data, x_data, mult_a, mult_b;
    logic signed [31:0] mult_out;
    logic signed [39:0] result;

    logic               busy32, mem_rd_en32, result_valid32;
    logic [9:0]         mem_addr32;
    logic signed [15:0] w_data32, x_data32, mult_a32, mult_b32;
    logic signed [31:0] mult_out32;
    logic signed [31:0] result32;

    logic signed [15:0] w_mem [0:1023];
    logic signed [15:0] x_mem [0:1023];

    int checkCount = 0;
    int passCount  = 0;

    always #5 clk = ~clk;

    neuron_mac_ctrl #(.INP_WIDTH(16), .ACC_WIDTH(40), .N_INPUTS(4), .ADDR_WIDTH(10)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bias(bias), .busy(busy),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .w_data(w_data), .x_data(x_data),
        .mult_a(mult_a), .mult_b(mult_b), .mult_out(mult_out), .result(result),
        .result_valid(result_valid), .result_ready(result_ready)
    );

    neuron_mac_ctrl #(.INP_WIDTH(16), .ACC_WIDTH(32), .N_INPUTS(4), .ADDR_WIDTH(10)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start), .bias(bias), .busy(busy32),
        .mem_rd_en(mem_rd_en32), .mem_addr(mem_addr32), .w_data(w_data32), .x_data(x_data32),
        .mult_a(mult_a32), .mult_b(mult_b32), .mult_out(mult_out32), .result(result32),
        .result_valid(result_valid32), .result_ready(result_ready)
    );

    // One-cycle-latency memories and combinational multipliers for each instance.
    always @(posedge clk) begin
        if (mem_rd_en) begin
            w_data <= w_mem[mem_addr];
            x_data <= x_mem[mem_addr];
        end
        if (mem_rd_en32) begin
            w_data32 <= w_mem[mem_addr32];
            x_data32 <= x_mem[mem_addr32];
        end
    end

    assign mult_out   = mult_a * mult_b;
    assign mult_out32 = mult_a32 * mult_b32;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive the inputs for the current cycle, then advance to the next one.
    task automatic applyStimulus(input logic s, input logic signed [15:0] b, input logic r);
        start        = s;
        bias         = b;
        result_ready = r;
        tick();
    endtask

    task automatic checkOutput(input string tag, input logic signed [63:0] observed,
                               input logic signed [63:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    endtask

    task automatic loadMem(input int w0, input int w1, input int w2, input int w3,
                           input int x0, input int x1, input int x2, input int x3);
        w_mem[0] = 16'(w0); w_mem[1] = 16'(w1); w_mem[2] = 16'(w2); w_mem[3] = 16'(w3);
        x_mem[0] = 16'(x0); x_mem[1] = 16'(x1); x_mem[2] = 16'(x2); x_mem[3] = 16'(x3);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) begin
            w_mem[i] = '0;
            x_mem[i] = '0;
        end
        rst_n = 1'b0;
        start = 1'b0;
        bias = '0;
        result_ready = 1'b1;
        tick();
        applyStimulus(0, 0, 1);

        $display("[TB] reset state");
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_rd_en", mem_rd_en, 0);
        checkOutput("rst_addr", mem_addr, 0);
        checkOutput("rst_valid", result_valid, 0);
        checkOutput("rst_result", result, 0);
        rst_n = 1'b1;
        applyStimulus(0, 0, 1);

        $display("[TB] basic dot product");
        loadMem(1, 2, 3, 4, 5, 6, 7, 8);
        applyStimulus(1, 10, 1);
        for (int i = 0; i < 4; i++) begin
            checkOutput("basic_busy", busy, 1);
            checkOutput("basic_rd_en", mem_rd_en, 1);
            checkOutput("basic_addr", mem_addr, i);
            checkOutput("basic_valid_early", result_valid, 0);
            applyStimulus(0, 0, 1);
        end
        checkOutput("tail_rd_en", mem_rd_en, 0);
        checkOutput("tail_addr_hold", mem_addr, 3);
        applyStimulus(0, 0, 1);
        checkOutput("bias_valid", result_valid, 0);
        applyStimulus(0, 0, 1);
        checkOutput("c7_valid", result_valid, 1);
        checkOutput("c7_result", result, 80);
        applyStimulus(0, 0, 1);
        checkOutput("c8_valid", result_valid, 0);
        checkOutput("c8_busy", busy, 0);

        $display("[TB] signed operands");
        loadMem(-3, 32767, -32768, 1, 7, 2, -1, -1);
        applyStimulus(1, -5, 1);
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 1);
        checkOutput("signed_valid", result_valid, 1);
        checkOutput("signed_result", result, 98275);
        applyStimulus(0, 0, 1);

        $display("[TB] backpressure");
        loadMem(1, 2, 3, 4, 5, 6, 7, 8);
        applyStimulus(1, 10, 0);
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            checkOutput("bp_valid", result_valid, 1);
            checkOutput("bp_result", result, 80);
            checkOutput("bp_busy", busy, 1);
            applyStimulus(0, 0, 0);
        end
        checkOutput("bp_valid_held", result_valid, 1);
        applyStimulus(0, 0, 1);
        checkOutput("bp_release_busy", busy, 0);
        checkOutput("bp_release_valid", result_valid, 0);

        $display("[TB] ignored start");
        applyStimulus(1, 10, 0);
        applyStimulus(0, 0, 0);
        applyStimulus(1, 999, 0);
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 0);
        checkOutput("ign_tail_rd_en", mem_rd_en, 0);
        applyStimulus(1, 999, 0);
        applyStimulus(1, 999, 0);
        checkOutput("ign_valid", result_valid, 1);
        checkOutput("ign_result", result, 80);
        checkOutput("ign_out_rd_en", mem_rd_en, 0);
        applyStimulus(1, 999, 1);
        checkOutput("ign_accept_busy", busy, 0);
        applyStimulus(0, 0, 1);
        checkOutput("ign_no_rerun_busy", busy, 0);
        checkOutput("ign_no_rerun_rd_en", mem_rd_en, 0);

        $display("[TB] reset mid-run");
        applyStimulus(1, 10, 1);
        applyStimulus(0, 0, 1);
        rst_n = 1'b0;
        applyStimulus(0, 0, 1);
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_rd_en", mem_rd_en, 0);
        checkOutput("mid_rst_addr", mem_addr, 0);
        checkOutput("mid_rst_valid", result_valid, 0);
        checkOutput("mid_rst_result", result, 0);
        rst_n = 1'b1;
        applyStimulus(0, 0, 1);
        applyStimulus(1, 10, 1);
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 1);
        checkOutput("post_rst_valid", result_valid, 1);
        checkOutput("post_rst_result", result, 80);
        applyStimulus(0, 0, 1);

        $display("[TB] wrap-around");
        loadMem(-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768);
        applyStimulus(1, 0, 1);
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 1);
        checkOutput("wrap32_valid", result_valid32, 1);
        checkOutput("wrap32_result", result32, 0);
        checkOutput("wide40_result", result, 64'sd4294967296);
        applyStimulus(0, 0, 1);
        checkOutput("wrap32_done", busy32, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
